// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the signals between the decode/pcnext side of the core and the PC
//   sequencer.
//   Signals:
//     stall      - current instruction not complete; the sequencer holds all state
//     pc_sel     - next-PC select: 00 INCREMENT, 01 BRANCH, 10 JUMP, 11 JR
//     is_true    - branch condition, meaningful only for BRANCH
//     pcnext_in  - control-transfer target computed by pcnext
//     pc         - address of the instruction being executed/fetched
//     in_delay   - current instruction is a branch delay slot
//     active     - core running (0 once halted)
//     retired    - completed-instruction count, wraps at 2^32
//   Modports:
//     master - the core side, which drives the control inputs
//     slave  - the sequencer, which drives pc/in_delay/active/retired
interface pc_sequencer_if;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        is_true;
  logic [31:0] pcnext_in;
  logic [31:0] pc;
  logic        in_delay;
  logic        active;
  logic [31:0] retired;

  modport master (
    output stall, pc_sel, is_true, pcnext_in,
    input  pc, in_delay, active, retired
  );

  modport slave (
    input  stall, pc_sel, is_true, pcnext_in,
    output pc, in_delay, active, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the architectural PC. It applies the MIPS branch delay slot, holds the PC
//   while the current instruction is stalled, and halts the core when a control
//   transfer targets HALT_ADDR. It also counts retired instructions.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high; overrides stall
//     bus    - pc_sequencer_if.slave (control inputs in, pc/in_delay/active/retired out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RUN   | normal sequential execution; taken transfers latch target
//   S_DELAY | executing the delay slot; next completion jumps to target
//   S_HALT  | jumped to HALT_ADDR; everything frozen until reset
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DELAY = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic [31:0] r_retired;
  logic        r_in_delay;
  logic        r_active;
  logic        w_taken;

  assign w_taken = (bus.pc_sel == 2'b10) || (bus.pc_sel == 2'b11) ||
                   ((bus.pc_sel == 2'b01) && bus.is_true);

  // in_delay/active are kept as their own flops, updated alongside the state,
  // so every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_VECTOR;
      r_target   <= 32'h0;
      r_retired  <= 32'h0;
      r_in_delay <= 1'b0;
      r_active   <= 1'b1;
    end else if (!bus.stall) begin
      case (r_state)
        S_RUN: begin
          r_pc      <= r_pc + 32'd4;
          r_retired <= r_retired + 32'd1;
          if (w_taken) begin
            r_target   <= bus.pcnext_in;
            r_state    <= S_DELAY;
            r_in_delay <= 1'b1;
          end
        end
        S_DELAY: begin
          // pc_sel is deliberately ignored here: a transfer in a delay slot has no effect.
          r_retired  <= r_retired + 32'd1;
          r_in_delay <= 1'b0;
          if (r_target == HALT_ADDR) begin
            r_pc     <= HALT_ADDR;
            r_state  <= S_HALT;
            r_active <= 1'b0;
          end else begin
            r_pc    <= r_target;
            r_state <= S_RUN;
          end
        end
        default: begin
          // S_HALT: frozen until reset, stall or not.
        end
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.in_delay = r_in_delay;
  assign bus.active   = r_active;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer. Inputs are driven between edges and outputs
//   are sampled 1 time unit after each rising edge. Expected values are constants
//   worked out by hand.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic dly,
                         input logic act, input logic [31:0] ret);
    chk({tag, ".pc"},       bus.pc,              pc);
    chk({tag, ".in_delay"}, {31'b0, bus.in_delay}, {31'b0, dly});
    chk({tag, ".active"},   {31'b0, bus.active},   {31'b0, act});
    chk({tag, ".retired"},  bus.retired,         ret);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic tru,
                       input logic [31:0] tgt);
    bus.stall     = st;
    bus.pc_sel    = sel;
    bus.is_true   = tru;
    bus.pcnext_in = tgt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 32'h0);
    do_reset();
    chk_all("rst", 32'hBFC0_0000, 1'b0, 1'b1, 32'd0);

    // Sequential increments
    step(); chk_all("inc1", 32'hBFC0_0004, 1'b0, 1'b1, 32'd1);
    step(); chk_all("inc2", 32'hBFC0_0008, 1'b0, 1'b1, 32'd2);
    step(); chk_all("inc3", 32'hBFC0_000C, 1'b0, 1'b1, 32'd3);

    // Jump from BFC00004 with delay slot
    do_reset();
    step(); chk_all("j.pre", 32'hBFC0_0004, 1'b0, 1'b1, 32'd1);
    drive(1'b0, 2'b10, 1'b0, 32'hBFC0_0100);
    step(); chk_all("j.slot", 32'hBFC0_0008, 1'b1, 1'b1, 32'd2);
    drive(1'b0, 2'b00, 1'b0, 32'h0);
    step(); chk_all("j.tgt", 32'hBFC0_0100, 1'b0, 1'b1, 32'd3);

    // Branch not taken: target ignored
    drive(1'b0, 2'b01, 1'b0, 32'hBFC0_0040);
    step(); chk_all("bnt", 32'hBFC0_0104, 1'b0, 1'b1, 32'd4);

    // Branch taken, with a jump inside the delay slot that must be ignored
    drive(1'b0, 2'b01, 1'b1, 32'hBFC0_0200);
    step(); chk_all("bt.slot", 32'hBFC0_0108, 1'b1, 1'b1, 32'd5);
    drive(1'b0, 2'b10, 1'b0, 32'hDEAD_BEEC);
    step(); chk_all("bt.tgt", 32'hBFC0_0200, 1'b0, 1'b1, 32'd6);

    // Stall in RUN holds everything
    drive(1'b1, 2'b10, 1'b0, 32'h1111_1110);
    step(); chk_all("stall.run", 32'hBFC0_0200, 1'b0, 1'b1, 32'd6);

    // Stall for 4 cycles mid-DELAY; target latched before the stall must win
    drive(1'b0, 2'b10, 1'b0, 32'hBFC0_0300);
    step(); chk_all("sd.slot", 32'hBFC0_0204, 1'b1, 1'b1, 32'd7);
    drive(1'b1, 2'b11, 1'b1, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      step(); chk_all("sd.hold", 32'hBFC0_0204, 1'b1, 1'b1, 32'd7);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0000_1234);
    step(); chk_all("sd.rel", 32'hBFC0_0300, 1'b0, 1'b1, 32'd8);

    // JR to HALT_ADDR: delay slot retires, then halt and freeze
    drive(1'b0, 2'b11, 1'b0, 32'h0);
    step(); chk_all("h.slot", 32'hBFC0_0304, 1'b1, 1'b1, 32'd9);
    drive(1'b0, 2'b00, 1'b0, 32'hBFC0_0800);
    step(); chk_all("h.halt", 32'h0000_0000, 1'b0, 1'b0, 32'd10);
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 2'b10, 1'b1, 32'hBFC0_0800);
      step(); chk_all("h.frozen", 32'h0000_0000, 1'b0, 1'b0, 32'd10);
    end

    // Reset while halted
    drive(1'b0, 2'b00, 1'b0, 32'h0);
    do_reset();
    chk_all("rst.halt", 32'hBFC0_0000, 1'b0, 1'b1, 32'd0);

    // Reset mid-DELAY with stall asserted; reset must win
    drive(1'b0, 2'b10, 1'b0, 32'hBFC0_0500);
    step(); chk_all("rd.slot", 32'hBFC0_0004, 1'b1, 1'b1, 32'd1);
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    do_reset();
    chk_all("rst.delay", 32'hBFC0_0000, 1'b0, 1'b1, 32'd0);
    drive(1'b0, 2'b00, 1'b0, 32'h0);
    step(); chk_all("rd.after", 32'hBFC0_0004, 1'b0, 1'b1, 32'd1);

    // pc+4 wraps past the top of the address space without halting
    drive(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC);
    step(); chk_all("w.slot", 32'hBFC0_0008, 1'b1, 1'b1, 32'd2);
    drive(1'b0, 2'b00, 1'b0, 32'h0);
    step(); chk_all("w.top", 32'hFFFF_FFFC, 1'b0, 1'b1, 32'd3);
    step(); chk_all("w.wrap", 32'h0000_0000, 1'b0, 1'b1, 32'd4);
    step(); chk_all("w.next", 32'h0000_0004, 1'b0, 1'b1, 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
